// File: rtl/prio_enc_rr.sv
// Registered priority encoder, fixed or round-robin.
// One-deep valid/ready output stage.
module prio_enc_rr #(
  parameter  int N  = 8,
  parameter  int RR = 0,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [W-1:0] fp_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] nxt_idx;
  logic [W-1:0] nxt_ptr;
  logic [W-1:0] j;
  logic         rr_hit;
  logic         nxt_any;
  logic         accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign nxt_any  = |in_req;

  always_comb begin
    fp_idx = '0;
    for (int i = 0; i < N; i++)
      if (in_req[i]) fp_idx = W'(i);
  end

  // Walk down from ptr, wrapping from 0 back to N-1.
  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    j      = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) >= k) ? W'(int'(ptr) - k)
                           : W'(int'(ptr) - k + N);
      if (!rr_hit && in_req[j]) begin
        rr_hit = 1'b1;
        rr_idx = j;
      end
    end
  end

  assign nxt_idx = (RR != 0) ? rr_idx : fp_idx;
  assign nxt_ptr = (nxt_idx == '0) ? W'(N - 1)
                                   : nxt_idx - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_any   <= 1'b0;
      ptr       <= W'(N - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_idx   <= nxt_any ? nxt_idx : '0;
      out_any   <= nxt_any;
      if (RR != 0 && nxt_any)
        ptr <= nxt_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 The block SHALL have parameter N, default 8, the number of request inputs (legal range 2..256).
REQ-002 The block SHALL have parameter RR, default 0: 0 selects fixed priority (highest index wins), 1 selects round-robin priority.
REQ-003 The block SHALL have derived localparam W = $clog2(N), the index width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_req holds a request vector to encode.
REQ-007 The block SHALL have port in_req, input, N bits: request vector, where bit i is request i.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a vector this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-010 The block SHALL have port out_idx, output, W bits: the encoded winning index.
REQ-011 The block SHALL have port out_any, output, 1 bit: the accepted vector had at least one bit set.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.

Function
REQ-013 in_ready SHALL be combinational: in_ready = !out_valid || out_ready.
REQ-014 An accept SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 On accept, the result SHALL be registered, so out_valid, out_idx and out_any are updated on the next rising edge (latency 1 cycle).
REQ-016 On a transfer with no accept in the same cycle, out_valid SHALL go to 0 on the next edge.
REQ-017 Accept and transfer in the same cycle SHALL load the new result with out_valid staying 1; no bubble and no lost result are allowed.
REQ-018 While out_valid=1 and out_ready=0, out_idx and out_any SHALL hold stable, and in_valid/in_req SHALL be ignored.
REQ-019 For an all-zero in_req, the registered out_any SHALL be 0 and out_idx SHALL be 0.
REQ-020 With RR=0, out_idx SHALL be the highest set bit index of in_req.
REQ-021 With RR=1, an internal pointer ptr (W bits, range 0..N-1) SHALL give the highest-priority index; the search SHALL go ptr, ptr-1, ..., 0, N-1, ..., ptr+1, and the first set bit wins.
REQ-022 With RR=1, on each accept with out_any=1, ptr SHALL be set to (idx==0 ? N-1 : idx-1), wrapping at N-1 for non-power-of-two N.
REQ-023 With RR=1, an accept with all-zero in_req, or a cycle with no accept, SHALL leave ptr unchanged.
REQ-024 With RR=0, ptr SHALL be unused and held at reset value.
REQ-025 ptr SHALL never hold a value of N or greater.
REQ-026 Outputs SHALL never be X after reset, for any in_req value.

Reset
REQ-027 When rst_n=0, the block SHALL set, asynchronously and immediately: out_valid=0, out_idx=0, out_any=0, ptr=N-1, and in_ready SHALL therefore read 1.
REQ-028 Reset asserted mid-operation SHALL discard any pending result; no transfer SHALL be presented after reset.
REQ-029 Reset deassertion SHALL be synchronised externally; the first accept is permitted on the first rising edge with rst_n=1.
REQ-030 With RR=1, the first grant after reset SHALL equal the fixed-priority result.

Verification (N=8)
REQ-031 The bench SHALL cover: RR=0, in_req=8'b0010_0110, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_any=1.
REQ-032 The bench SHALL cover: RR=0, in_req=8'h00 accepted -> out_valid=1, out_any=0, out_idx=0.
REQ-033 The bench SHALL cover: RR=1, in_req=8'hFF held, in_valid=1, out_ready=1 -> out_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
REQ-034 The bench SHALL cover: RR=1, in_req=8'b1000_0001 held -> out_idx alternates 7,0,7,0; then in_req=8'h00 -> out_any=0 and the next 8'b1000_0001 grant continues the alternation.
REQ-035 The bench SHALL cover: result pending, out_ready=0 for 5 cycles with in_req changing -> in_ready=0, out_idx/out_any stable; then out_ready=1 with in_valid=1 -> back-to-back load with out_valid held 1.
REQ-036 The bench SHALL cover: RR=1, rst_n pulsed low mid-stream after grant 4 -> out_valid=0 immediately; after release, in_req=8'hFF -> out_idx=7.
